parking_gate_scheduler: RTL

- Sequences a single shared barrier gate between two requesters: the entry lane (password-gated) and the exit lane.
- Tracks lot occupancy against capacity and locks out the entry lane after repeated wrong passwords.
- Sits between the lane sensors/keypad and the gate actuator/LED drivers of the parking system.

---
 rtl/parking_gate_scheduler_if.sv | 36 +++
 rtl/parking_gate_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_scheduler_if.sv
// Lane-side bundle of the parking gate scheduler: sensors and keypad in,
// gate actuator, LEDs and status out. The scheduler uses the slave modport.
// The system side (sensors, keypad, actuator drivers) uses master.
interface parking_gate_scheduler_if #(
  parameter int CAPACITY = 8
);
  localparam int CNT_W = $clog2(CAPACITY + 1);

  logic             sensor_entrance;
  logic             sensor_exit;
  logic [3:0]       password;
  logic             pw_valid;
  logic             car_passed;

  logic             gate_open;
  logic             grant_in;
  logic             grant_out;
  logic             GREEN_LED;
  logic             RED_LED;
  logic [CNT_W-1:0] countcar;
  logic             lot_full;
  logic             lockout;
  logic [2:0]       indicator;

  modport master (
    output sensor_entrance, sensor_exit, password, pw_valid, car_passed,
    input  gate_open, grant_in, grant_out, GREEN_LED, RED_LED,
           countcar, lot_full, lockout, indicator
  );

  modport slave (
    input  sensor_entrance, sensor_exit, password, pw_valid, car_passed,
    output gate_open, grant_in, grant_out, GREEN_LED, RED_LED,
           countcar, lot_full, lockout, indicator
  );
endinterface

// File: rtl/parking_gate_scheduler.sv
// Parking gate scheduler: arbitrates one barrier gate between a
// password-gated entry lane and an exit lane, tracks occupancy against
// CAPACITY and locks the entry lane out after MAX_TRIES wrong codes.
// Optional build macro CPS_EXIT_PRIORITY_EN: when defined, the exit lane
// wins every IDLE tie; otherwise ties are resolved round-robin.
module parking_gate_scheduler #(
  parameter int         CAPACITY       = 8,
  parameter logic [3:0] PASSWORD       = 4'b1011,
  parameter int         OPEN_CYCLES    = 16,
  parameter int         PW_TIMEOUT     = 32,
  parameter int         MAX_TRIES      = 3,
  parameter int         LOCKOUT_CYCLES = 64
) (
  input logic                     clk,
  input logic                     reset_n,
  parking_gate_scheduler_if.slave bus
);

  localparam int CNT_W   = $clog2(CAPACITY + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int LT_W    = $clog2(LOCKOUT_CYCLES + 1);
  localparam int TMR_MAX = (PW_TIMEOUT > OPEN_CYCLES) ? PW_TIMEOUT : OPEN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);

  // State encoding doubles as the indicator code.
  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_WAIT_PW  = 3'b001,
    S_OPEN_IN  = 3'b010,
    S_OPEN_OUT = 3'b011,
    S_WRONG_PW = 3'b100
  } state_t;

  typedef enum logic {
    LANE_EXIT  = 1'b0,
    LANE_ENTRY = 1'b1
  } lane_t;

  state_t           r_state;
  lane_t            r_last;
  logic [CNT_W-1:0] r_count;
  logic [TRY_W-1:0] r_tries;
  logic [TMR_W-1:0] r_timer;       // cycles already spent in the current grant state
  logic             r_lockout;
  logic [LT_W-1:0]  r_lock_timer;
  logic             r_gate_open;
  logic             r_grant_in;
  logic             r_grant_out;
  logic             r_green;
  logic             r_red;
  logic             r_lot_full;
  logic [2:0]       r_indicator;

  state_t           w_state_nxt;
  lane_t            w_last_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [TRY_W-1:0] w_tries_nxt;
  logic [TMR_W-1:0] w_timer_nxt;
  logic             w_lockout_nxt;
  logic [LT_W-1:0]  w_lock_timer_nxt;
  logic             w_full_nxt;
  logic             w_entry_ok;
  logic             w_exit_ok;
  logic             w_pick_entry;
  logic             w_pw_expired;
  logic             w_open_expired;

  assign w_entry_ok     = bus.sensor_entrance & ~r_lot_full & ~r_lockout;
  assign w_exit_ok      = bus.sensor_exit;
  assign w_pw_expired   = (r_timer == TMR_W'(PW_TIMEOUT - 1));
  assign w_open_expired = (r_timer == TMR_W'(OPEN_CYCLES - 1));

  // Tie-break between two eligible lanes in IDLE.
  always_comb begin
`ifdef CPS_EXIT_PRIORITY_EN
    w_pick_entry = 1'b0;
`else
    w_pick_entry = (r_last == LANE_EXIT);
`endif
  end

  // Next-state, counter and lockout-timer decisions for the coming edge.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (which would infer a latch).
    w_state_nxt      = r_state;
    w_last_nxt       = r_last;
    w_count_nxt      = r_count;
    w_tries_nxt      = r_tries;
    w_timer_nxt      = r_timer + 1'b1;
    w_lockout_nxt    = r_lockout;
    w_lock_timer_nxt = r_lock_timer;

    // Lockout runs on its own, regardless of what the gate is doing.
    if (r_lockout) begin
      w_lock_timer_nxt = r_lock_timer - 1'b1;
      if (r_lock_timer == LT_W'(1)) w_lockout_nxt = 1'b0;
    end

    unique case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (w_entry_ok && w_exit_ok) begin
          w_state_nxt = w_pick_entry ? S_WAIT_PW : S_OPEN_OUT;
        end else if (w_entry_ok) begin
          w_state_nxt = S_WAIT_PW;
        end else if (w_exit_ok) begin
          w_state_nxt = S_OPEN_OUT;
        end
      end

      S_WAIT_PW: begin
        if (bus.pw_valid) begin
          w_timer_nxt = '0;
          if (bus.password == PASSWORD) begin
            w_state_nxt = S_OPEN_IN;
            w_tries_nxt = '0;
          end else begin
            w_state_nxt = S_WRONG_PW;
            w_tries_nxt = r_tries + 1'b1;
          end
        end else if (w_pw_expired) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = LANE_ENTRY;
        end
      end

      S_WRONG_PW: begin
        w_timer_nxt = '0;
        if (r_tries == TRY_W'(MAX_TRIES)) begin
          w_lockout_nxt    = 1'b1;
          w_lock_timer_nxt = LT_W'(LOCKOUT_CYCLES);
          w_tries_nxt      = '0;
          w_state_nxt      = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_PW;
        end
      end

      S_OPEN_IN: begin
        if (bus.car_passed) begin
          if (r_count != CNT_W'(CAPACITY)) w_count_nxt = r_count + 1'b1;
          w_last_nxt  = LANE_ENTRY;
          w_state_nxt = S_IDLE;
        end else if (w_open_expired) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_OPEN_OUT: begin
        if (bus.car_passed) begin
          if (r_count != '0) w_count_nxt = r_count - 1'b1;
          w_last_nxt  = LANE_EXIT;
          w_state_nxt = S_IDLE;
        end else if (w_open_expired) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_full_nxt = (w_count_nxt == CNT_W'(CAPACITY));

  // FSM state, counters and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last       <= LANE_EXIT;
      r_count      <= '0;
      r_tries      <= '0;
      r_timer      <= '0;
      r_lockout    <= 1'b0;
      r_lock_timer <= '0;
      r_gate_open  <= 1'b0;
      r_grant_in   <= 1'b0;
      r_grant_out  <= 1'b0;
      r_green      <= 1'b0;
      r_red        <= 1'b0;
      r_lot_full   <= 1'b0;
      r_indicator  <= 3'b000;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values, independent of statement order.
      r_state      <= w_state_nxt;
      r_last       <= w_last_nxt;
      r_count      <= w_count_nxt;
      r_tries      <= w_tries_nxt;
      r_timer      <= w_timer_nxt;
      r_lockout    <= w_lockout_nxt;
      r_lock_timer <= w_lock_timer_nxt;
      r_gate_open  <= (w_state_nxt == S_OPEN_IN) || (w_state_nxt == S_OPEN_OUT);
      r_green      <= (w_state_nxt == S_OPEN_IN) || (w_state_nxt == S_OPEN_OUT);
      r_grant_in   <= (w_state_nxt == S_WAIT_PW) || (w_state_nxt == S_WRONG_PW) ||
                      (w_state_nxt == S_OPEN_IN);
      r_grant_out  <= (w_state_nxt == S_OPEN_OUT);
      r_red        <= (w_state_nxt == S_WRONG_PW) || w_lockout_nxt || w_full_nxt;
      r_lot_full   <= w_full_nxt;
      r_indicator  <= w_state_nxt;
    end
  end

  assign bus.gate_open = r_gate_open;
  assign bus.grant_in  = r_grant_in;
  assign bus.grant_out = r_grant_out;
  assign bus.GREEN_LED = r_green;
  assign bus.RED_LED   = r_red;
  assign bus.countcar  = r_count;
  assign bus.lot_full  = r_lot_full;
  assign bus.lockout   = r_lockout;
  assign bus.indicator = r_indicator;

endmodule
